// File: rtl/mask_loader_pkg.sv
// Shared state encoding and default geometry for the edge-mask SRAM loader.
package mask_loader_pkg;
    localparam int ADDRW_DEF = 19;
    localparam int DATAW_DEF = 128;
    localparam int MASKW_DEF = 2048;
    localparam int WORDS     = MASKW_DEF / DATAW_DEF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Index counter width; never zero so a single-word mask still elaborates.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction
endpackage

// File: rtl/mask_sram_loader_if.sv
// Beat stream between the mask loader (master) and the SRAM controller (slave).
interface mask_sram_loader_if
    import mask_loader_pkg::*;
#(
    parameter int ADDRW = ADDRW_DEF,
    parameter int DATAW = DATAW_DEF
);
    logic             stream_valid;
    logic             stream_ready;
    logic             mode_R1_W0;
    logic [ADDRW-1:0] SRAM_ADDR_Stream;
    logic [DATAW-1:0] SRAM_DATA_IN_Stream;
    logic [DATAW-1:0] SRAM_DATA_OUT_Stream;
    logic             rd_valid;

    modport master (
        output stream_valid, mode_R1_W0, SRAM_ADDR_Stream, SRAM_DATA_IN_Stream,
        input  stream_ready, SRAM_DATA_OUT_Stream, rd_valid
    );

    modport slave (
        input  stream_valid, mode_R1_W0, SRAM_ADDR_Stream, SRAM_DATA_IN_Stream,
        output stream_ready, SRAM_DATA_OUT_Stream, rd_valid
    );
endinterface

// File: rtl/mask_sram_loader.sv
// Streams a snapshotted edge mask into SRAM one DATAW word per beat.
// Optional readback-and-compare pass is compiled in with LOADER_READBACK_EN.
module mask_sram_loader
    import mask_loader_pkg::*;
#(
    parameter int ADDRW = ADDRW_DEF,
    parameter int DATAW = DATAW_DEF,
    parameter int MASKW = MASKW_DEF
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               start,
    input  logic [ADDRW-1:0]   base_addr,
    input  logic [MASKW-1:0]   edge_mask,
    output logic               busy,
    output logic               done,
    output logic               mismatch,
    mask_sram_loader_if.master sram
);
    localparam int              NWORDS   = MASKW / DATAW;
    localparam int              IDXW     = idx_width(NWORDS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

    state_t           r_state;
    logic [MASKW-1:0] r_snap;
    logic [ADDRW-1:0] r_base;
    logic [IDXW-1:0]  r_idx;
    logic             r_valid;
    logic             r_mode;
    logic             r_done;
    logic             r_mismatch;
    logic [ADDRW-1:0] r_addr;
    logic [DATAW-1:0] r_data;

    logic [DATAW-1:0] w_words [NWORDS];
    logic [IDXW-1:0]  w_idx_inc;
    logic             w_accept;

    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_word
            assign w_words[gi] = r_snap[gi*DATAW +: DATAW];
        end
    endgenerate

    assign w_idx_inc = r_idx + IDXW'(1);
    assign w_accept  = r_valid & sram.stream_ready;

`ifdef LOADER_READBACK_EN
    logic w_rd_bad;
    assign w_rd_bad = (sram.SRAM_DATA_OUT_Stream != w_words[r_idx]);
    assign mismatch = r_mismatch;
`else
    logic w_unused_rd;
    assign w_unused_rd = ^{sram.SRAM_DATA_OUT_Stream, sram.rd_valid, r_base, r_mismatch};
    assign mismatch    = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_valid    <= 1'b0;
            r_mode     <= 1'b0;
            r_done     <= 1'b0;
            r_mismatch <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        // Word 0 comes straight from the input; the snapshot lands this same edge.
                        r_snap     <= edge_mask;
                        r_base     <= base_addr;
                        r_idx      <= '0;
                        r_mismatch <= 1'b0;
                        r_addr     <= base_addr;
                        r_data     <= edge_mask[DATAW-1:0];
                        r_mode     <= 1'b0;
                        r_valid    <= 1'b1;
                        r_state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (w_accept) begin
                        if (r_idx == LAST_IDX) begin
`ifdef LOADER_READBACK_EN
                            r_state <= RD_REQ;
                            r_mode  <= 1'b1;
                            r_addr  <= r_base;
                            r_idx   <= '0;
                            r_data  <= w_words[0];
`else
                            r_state <= DONE;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
`endif
                        end else begin
                            r_idx  <= w_idx_inc;
                            r_addr <= r_addr + ADDRW'(1);
                            r_data <= w_words[w_idx_inc];
                        end
                    end
                end
`ifdef LOADER_READBACK_EN
                RD_REQ: begin
                    if (w_accept) begin
                        r_valid <= 1'b0;
                        r_state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (sram.rd_valid) begin
                        if (w_rd_bad)
                            r_mismatch <= 1'b1;
                        if (r_idx == LAST_IDX) begin
                            r_state <= DONE;
                            r_mode  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx   <= w_idx_inc;
                            r_addr  <= r_addr + ADDRW'(1);
                            r_data  <= w_words[w_idx_inc];
                            r_valid <= 1'b1;
                            r_state <= RD_REQ;
                        end
                    end
                end
`endif
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy                     = (r_state != IDLE);
    assign done                     = r_done;
    assign sram.stream_valid        = r_valid;
    assign sram.mode_R1_W0          = r_mode;
    assign sram.SRAM_ADDR_Stream    = r_addr;
    assign sram.SRAM_DATA_IN_Stream = r_data;
endmodule

// File: tb/tb_mask_sram_loader.sv
// Scoreboard bench for mask_sram_loader: stimulus pushes expected beats, a monitor pops and compares.
// Build with +define+LOADER_READBACK_EN to also exercise the readback pass.
module tb_mask_sram_loader;
    import mask_loader_pkg::*;

    localparam int AW = ADDRW_DEF;
    localparam int DW = DATAW_DEF;
    localparam int MW = MASKW_DEF;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [MW-1:0] edge_mask = '0;
    logic          busy;
    logic          done;
    logic          mismatch;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mask_sram_loader_if #(.ADDRW(AW), .DATAW(DW)) sif ();

    mask_sram_loader #(.ADDRW(AW), .DATAW(DW), .MASKW(MW)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .start     (start),
        .base_addr (base_addr),
        .edge_mask (edge_mask),
        .busy      (busy),
        .done      (done),
        .mismatch  (mismatch),
        .sram      (sif.master)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Scoreboard of expected beats plus an SRAM image built from accepted writes.
    logic [AW-1:0] q_addr [$];
    logic [DW-1:0] q_data [$];
    logic          q_mode [$];
    logic [DW-1:0] mem [logic [AW-1:0]];

    // stream_ready: held at 1, or toggled every cycle.
    logic ready_tog = 1'b0;
    always @(posedge CLK) begin
        #1;
        sif.stream_ready = ready_tog ? ~sif.stream_ready : 1'b1;
    end

`ifdef LOADER_READBACK_EN
    logic [AW-1:0] rb_q [$];
    logic [AW-1:0] corrupt_addr = '0;
    logic          corrupt_en = 1'b0;
    initial begin
        logic [AW-1:0] a;
        sif.rd_valid = 1'b0;
        sif.SRAM_DATA_OUT_Stream = '0;
        forever begin
            @(posedge CLK);
            #1;
            sif.rd_valid = 1'b0;
            if (rb_q.size() > 0 && RSTn) begin
                a = rb_q.pop_front();
                @(posedge CLK);
                #1;
                sif.SRAM_DATA_OUT_Stream = mem.exists(a) ? mem[a] : '0;
                if (corrupt_en && a == corrupt_addr)
                    sif.SRAM_DATA_OUT_Stream[5] = ~sif.SRAM_DATA_OUT_Stream[5];
                sif.rd_valid = 1'b1;
            end
        end
    end
`else
    initial begin
        sif.rd_valid = 1'b0;
        sif.SRAM_DATA_OUT_Stream = '0;
    end
`endif

    // Monitor
    int            n_beats = 0;
    int            n_done = 0;
    int            done_cyc = 0;
    logic          mm_at_done = 1'b0;
    logic          p_valid = 1'b0, p_ready = 1'b0, p_mode = 1'b0, p_rst = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_data = '0;

    always @(negedge CLK) begin : mon
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          em;
        if (RSTn && p_rst && p_valid && !p_ready)
            check("hold_stable",
                  sif.stream_valid === 1'b1 && sif.SRAM_ADDR_Stream === p_addr &&
                  sif.SRAM_DATA_IN_Stream === p_data && sif.mode_R1_W0 === p_mode,
                  $sformatf("got valid=%b addr=%h mode=%b, required valid=1 addr=%h mode=%b",
                            sif.stream_valid, sif.SRAM_ADDR_Stream, sif.mode_R1_W0, p_addr, p_mode));
        if (sif.stream_valid === 1'b1 && sif.stream_ready === 1'b1) begin
            n_beats++;
            if (q_addr.size() == 0) begin
                check("beat_expected", 1'b0,
                      $sformatf("got beat addr=%h mode=%b, required no beat",
                                sif.SRAM_ADDR_Stream, sif.mode_R1_W0));
            end else begin
                ea = q_addr.pop_front();
                ed = q_data.pop_front();
                em = q_mode.pop_front();
                if (em) begin
                    check("read_beat", sif.SRAM_ADDR_Stream === ea && sif.mode_R1_W0 === 1'b1,
                          $sformatf("got addr=%h mode=%b, required addr=%h mode=1",
                                    sif.SRAM_ADDR_Stream, sif.mode_R1_W0, ea));
`ifdef LOADER_READBACK_EN
                    rb_q.push_back(sif.SRAM_ADDR_Stream);
`endif
                end else begin
                    check("write_beat",
                          sif.SRAM_ADDR_Stream === ea && sif.mode_R1_W0 === 1'b0 &&
                          sif.SRAM_DATA_IN_Stream === ed,
                          $sformatf("got addr=%h mode=%b data=%h, required addr=%h mode=0 data=%h",
                                    sif.SRAM_ADDR_Stream, sif.mode_R1_W0, sif.SRAM_DATA_IN_Stream, ea, ed));
                    mem[sif.SRAM_ADDR_Stream] = sif.SRAM_DATA_IN_Stream;
                end
            end
        end
        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
            mm_at_done = mismatch;
        end
        p_valid = sif.stream_valid;
        p_ready = sif.stream_ready;
        p_mode  = sif.mode_R1_W0;
        p_addr  = sif.SRAM_ADDR_Stream;
        p_data  = sif.SRAM_DATA_IN_Stream;
        p_rst   = RSTn;
    end

    // Word k of the mask is sixteen copies of byte (b0 + k).
    task automatic build_mask(input logic [7:0] b0, output logic [MW-1:0] m);
        logic [7:0] b;
        for (int k = 0; k < WORDS; k++) begin
            b = b0 + 8'(k);
            m[k*DW +: DW] = {16{b}};
        end
    endtask

    task automatic push_load(input logic [AW-1:0] base, input logic [MW-1:0] m);
        for (int k = 0; k < WORDS; k++) begin
            q_addr.push_back(base + AW'(k));
            q_data.push_back(m[k*DW +: DW]);
            q_mode.push_back(1'b0);
        end
`ifdef LOADER_READBACK_EN
        for (int k = 0; k < WORDS; k++) begin
            q_addr.push_back(base + AW'(k));
            q_data.push_back('0);
            q_mode.push_back(1'b1);
        end
`endif
    endtask

    // Called just after a rising edge; returns the cycle count of the accepting edge.
    task automatic start_load(input logic [AW-1:0] base, input logic [MW-1:0] m, output int s);
        base_addr = base;
        edge_mask = m;
        push_load(base, m);
        start = 1'b1;
        @(posedge CLK);
        #1;
        s = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0, input string nm);
        int t;
        t = 0;
        while (n_done == n0 && t < 400) begin
            @(posedge CLK);
            #1;
            t++;
        end
        check(nm, n_done == n0 + 1, $sformatf("got %0d done pulses, required 1", n_done - n0));
    endtask

    task automatic flush_sb();
        q_addr.delete();
        q_data.delete();
        q_mode.delete();
`ifdef LOADER_READBACK_EN
        rb_q.delete();
`endif
    endtask

`ifdef LOADER_READBACK_EN
    localparam int BEATS = 2 * WORDS;
`else
    localparam int BEATS = WORDS;
`endif

    initial begin
        logic [MW-1:0] m;
        int s, b0, d0, t;

        repeat (3) @(posedge CLK);
        #1;
        check("reset_state",
              busy === 1'b0 && done === 1'b0 && mismatch === 1'b0 && sif.stream_valid === 1'b0 &&
              sif.mode_R1_W0 === 1'b0 && sif.SRAM_ADDR_Stream === '0 && sif.SRAM_DATA_IN_Stream === '0,
              $sformatf("got busy=%b done=%b valid=%b mode=%b addr=%h, required all 0",
                        busy, done, sif.stream_valid, sif.mode_R1_W0, sif.SRAM_ADDR_Stream));
        RSTn = 1'b1;
        @(posedge CLK);
        #1;

        // 1: base 0, ready held high
        build_mask(8'h00, m);
        b0 = n_beats; d0 = n_done;
        start_load(19'h00000, m, s);
        check("busy_after_start", busy === 1'b1, $sformatf("got %b, required 1", busy));
        wait_done(d0, "done_once_basic");
`ifndef LOADER_READBACK_EN
        check("done_cycle", done_cyc - s + 1 == 17, $sformatf("got cycle %0d, required 17", done_cyc - s + 1));
`endif
        check("beats_basic", n_beats - b0 == BEATS, $sformatf("got %0d, required %0d", n_beats - b0, BEATS));
        check("idle_after_done", busy === 1'b0 && sif.stream_valid === 1'b0,
              $sformatf("got busy=%b valid=%b, required 0 0", busy, sif.stream_valid));
        check("mem_word15", mem[19'h0000F] === {16{8'h0F}},
              $sformatf("got %h, required %h", mem[19'h0000F], {16{8'h0F}}));

        // 2: stream_ready toggling every cycle
        ready_tog = 1'b1;
        build_mask(8'hA0, m);
        b0 = n_beats; d0 = n_done;
        start_load(19'h00123, m, s);
        wait_done(d0, "done_once_toggle");
        check("beats_toggle", n_beats - b0 == BEATS, $sformatf("got %0d, required %0d", n_beats - b0, BEATS));
        ready_tog = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        // 3: address wrap from 7FFF8
        build_mask(8'h50, m);
        b0 = n_beats; d0 = n_done;
        start_load(19'h7FFF8, m, s);
        wait_done(d0, "done_once_wrap");
        check("wrap_top", mem[19'h7FFFF] === {16{8'h57}},
              $sformatf("got %h, required %h", mem[19'h7FFFF], {16{8'h57}}));
        check("wrap_zero", mem[19'h00000] === {16{8'h58}},
              $sformatf("got %h, required %h", mem[19'h00000], {16{8'h58}}));
        check("sb_empty_wrap", q_addr.size() == 0, $sformatf("got %0d pending, required 0", q_addr.size()));

        // 4: start re-pulsed and edge_mask changed mid-load
        build_mask(8'h30, m);
        b0 = n_beats; d0 = n_done;
        start_load(19'h00200, m, s);
        repeat (3) @(posedge CLK);
        #1;
        edge_mask = ~m;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        wait_done(d0, "done_once_restart");
        repeat (20) @(posedge CLK);
        #1;
        check("no_restart", n_done == d0 + 1 && busy === 1'b0 && n_beats - b0 == BEATS,
              $sformatf("got done=%0d beats=%0d busy=%b, required 1 %0d 0", n_done - d0, n_beats - b0, busy, BEATS));

        // 5: reset at beat 5
        build_mask(8'hC0, m);
        b0 = n_beats; d0 = n_done;
        start_load(19'h00400, m, s);
        t = 0;
        while (n_beats - b0 < 5 && t < 100) begin
            @(posedge CLK);
            #1;
            t++;
        end
        check("reach_beat5", n_beats - b0 >= 5, $sformatf("got %0d beats, required 5", n_beats - b0));
        RSTn = 1'b0;
        @(posedge CLK);
        #1;
        check("abort_outputs",
              busy === 1'b0 && done === 1'b0 && mismatch === 1'b0 && sif.stream_valid === 1'b0 &&
              sif.mode_R1_W0 === 1'b0 && sif.SRAM_ADDR_Stream === '0 && sif.SRAM_DATA_IN_Stream === '0,
              $sformatf("got busy=%b done=%b valid=%b mode=%b addr=%h, required all 0",
                        busy, done, sif.stream_valid, sif.mode_R1_W0, sif.SRAM_ADDR_Stream));
        flush_sb();
        RSTn = 1'b1;
        repeat (25) @(posedge CLK);
        #1;
        check("abort_no_done", n_done == d0 && busy === 1'b0,
              $sformatf("got done=%0d busy=%b, required 0 0", n_done - d0, busy));

`ifdef LOADER_READBACK_EN
        // 6: readback with word 3 corrupted, then intact
        build_mask(8'h10, m);
        corrupt_addr = 19'h00603;
        corrupt_en = 1'b1;
        d0 = n_done;
        start_load(19'h00600, m, s);
        wait_done(d0, "done_once_rb_bad");
        check("mismatch_set", mm_at_done === 1'b1, $sformatf("got %b, required 1", mm_at_done));
        check("mismatch_sticky", mismatch === 1'b1, $sformatf("got %b, required 1", mismatch));
        corrupt_en = 1'b0;
        build_mask(8'h20, m);
        d0 = n_done;
        start_load(19'h00700, m, s);
        check("mismatch_cleared", mismatch === 1'b0, $sformatf("got %b, required 0", mismatch));
        wait_done(d0, "done_once_rb_ok");
        check("mismatch_clean", mm_at_done === 1'b0, $sformatf("got %b, required 0", mm_at_done));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish by 400000, required finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mask_sram_loader.md
MASK_SRAM_LOADER -- requirements
Module: mask_sram_loader

Interface
REQ-001 SHALL have parameter ADDRW, default 19, meaning SRAM word-address width.
REQ-002 SHALL have parameter DATAW, default 128, meaning SRAM stream data width (four 32-bit banks side by side).
REQ-003 SHALL have parameter MASKW, default 2048, meaning edge-mask width; MASKW SHALL be a multiple of DATAW.
REQ-004 SHALL have port CLK  in  1  the single clock; all logic on the rising edge.
REQ-005 SHALL have port RSTn  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  in  1  load request; sampled only in IDLE.
REQ-007 SHALL have port base_addr  in  ADDRW  first SRAM address of the load.
REQ-008 SHALL have port edge_mask  in  MASKW  mask from the parameter checker.
REQ-009 SHALL have port busy  out  1  high in every state except IDLE.
REQ-010 SHALL have port done  out  1  one-cycle completion pulse.
REQ-011 SHALL have port mode_R1_W0  out  1  stream direction: 1 read, 0 write.
REQ-012 SHALL have port SRAM_ADDR_Stream  out  ADDRW  address of the current beat.
REQ-013 SHALL have port SRAM_DATA_IN_Stream  out  DATAW  write data of the current beat.
REQ-014 SHALL have port stream_valid  out  1  beat offered to the SRAM controller.
REQ-015 SHALL have port stream_ready  in  1  SRAM controller accepts the beat.
REQ-016 SHALL have port SRAM_DATA_OUT_Stream  in  DATAW  read data; used only with LOADER_READBACK_EN.
REQ-017 SHALL have port rd_valid  in  1  read data valid; used only with LOADER_READBACK_EN.
REQ-018 SHALL have port mismatch  out  1  sticky readback-compare error; constant 0 without LOADER_READBACK_EN.

Function
REQ-019 SHALL implement the states IDLE, WRITE, RD_REQ, RD_WAIT and DONE.
REQ-020 SHALL, in IDLE with start=1, snapshot edge_mask and base_addr, clear the word index and mismatch, and go to WRITE.
REQ-021 SHALL ignore start in any state other than IDLE, with no queuing.
REQ-022 SHALL present word k as snapshot[DATAW*k+DATAW-1:DATAW*k] at address base_addr+k, for k = 0..MASKW/DATAW-1 (16 words by default).
REQ-023 SHALL compute addresses modulo 2^ADDRW, so that 19'h7FFFF+1 wraps to 0.
REQ-024 SHALL transfer a beat only when stream_valid and stream_ready are both 1 in the same cycle.
REQ-025 SHALL hold stream_valid, address, data and mode stable until the beat is accepted.
REQ-026 SHALL drive mode_R1_W0=0 in WRITE and 1 in RD_REQ and RD_WAIT.
REQ-027 SHALL, with stream_ready held at 1 and start accepted at cycle 0, assert stream_valid in cycles 1..16 and done in cycle 17.
REQ-028 SHALL leave WRITE after the last word is accepted: to RD_REQ when readback is enabled, otherwise to DONE.
REQ-029 SHALL hold DONE for exactly one cycle with done=1 and busy=1, then return to IDLE.
REQ-030 SHALL have stream_valid=0 in IDLE, RD_WAIT and DONE.
REQ-031 SHALL update edge_mask snapshots only on an accepted start; a mid-load edge_mask change SHALL have no effect on the load.
REQ-032 SHALL hold mismatch until the next accepted start.

Reset
REQ-033 SHALL, when RSTn=0 at a clock edge, force IDLE with busy, done, stream_valid, mode_R1_W0, mismatch, SRAM_ADDR_Stream and SRAM_DATA_IN_Stream all 0.
REQ-034 SHALL abort any load in progress on reset, with no done pulse.

Configuration
REQ-035 SHALL compile readback in only when macro LOADER_READBACK_EN is defined.
REQ-036 SHALL, when readback is enabled, re-walk all words after WRITE: RD_REQ issues a read beat for word k, RD_WAIT waits for rd_valid, and the received data is compared with word k.
REQ-037 SHALL set mismatch on any inequality and then advance to word k+1, or to DONE after the last word.
REQ-038 SHALL allow only one read outstanding at a time.
REQ-039 SHALL ignore rd_valid outside RD_WAIT.
REQ-040 SHALL, when the macro is undefined, never enter RD_REQ or RD_WAIT, tie mismatch to 0, and leave SRAM_DATA_OUT_Stream and rd_valid unused.

Structure
REQ-041 SHALL take the state enum, the ADDRW/DATAW/MASKW defaults and the WORDS=MASKW/DATAW constant from the shared package mask_loader_pkg.
REQ-042 SHALL be a single module with no sub-module, holding the snapshot in one register and selecting the word by index mux.

Verification
REQ-043 SHALL cover: base_addr=0, edge_mask=word k filled with byte k, stream_ready=1 -> 16 beats at addresses 0..15 carrying the correct data, done in cycle 17.
REQ-044 SHALL cover: stream_ready toggling 1/0 every cycle -> each beat held stable until accepted, 16 transfers total, done exactly once.
REQ-045 SHALL cover: base_addr=19'h7FFF8 -> addresses 7FFF8..7FFFF followed by 0..7.
REQ-046 SHALL cover: start pulsed and edge_mask changed during WRITE -> no restart, and the original snapshot is written.
REQ-047 SHALL cover: RSTn=0 at beat 5 -> next cycle IDLE with all outputs 0 and no done pulse.
REQ-048 SHALL cover, with LOADER_READBACK_EN: read data corrupted on word 3 -> mismatch=1 at done and cleared by the next start; with data intact -> mismatch=0.
